// File: rtl/fmap_stream_reader.sv
// Streams a CHANNELS x IN_HEIGHT x IN_WIDTH feature map out of BRAM (addresses 0..TOTAL-1), tagging each element with its channel.
// First element valid 2 cycles after start, then 1/cycle; m_ready low stalls reads via a 2-entry FIFO so no read datum is ever dropped.
module fmap_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 128,
    parameter int IN_HEIGHT  = 3,
    parameter int IN_WIDTH   = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int CH_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CH_WIDTH-1:0]   m_chan,
    output logic                  m_last
);
    localparam int TOTAL = CHANNELS * IN_HEIGHT * IN_WIDTH;
    localparam int PLANE = IN_HEIGHT * IN_WIDTH;
    localparam int PIX_W = (PLANE > 1) ? $clog2(PLANE) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL - 1);
    localparam logic [PIX_W-1:0]      LAST_PIX  = PIX_W'(PLANE - 1);
    localparam logic [CH_WIDTH-1:0]   LAST_CH   = CH_WIDTH'(CHANNELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_dvld;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_cnt;
    logic [PIX_W-1:0]      r_pix;
    logic [CH_WIDTH-1:0]   r_ch;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_issue;
    logic                  w_plane_end;
    logic                  w_last_elem;
    logic [2:0]            w_commit;

    always_comb begin
        w_pop       = (r_cnt != 2'd0) && m_ready;
        // Slots already spoken for: buffered data plus the datum now on bram_dout, less what leaves this cycle.
        w_commit    = {1'b0, r_cnt} + {2'b00, r_dvld} - {2'b00, w_pop};
        w_issue     = (r_state == S_RUN) && (w_commit < 3'd2);
        w_plane_end = (r_pix == LAST_PIX);
        w_last_elem = w_plane_end && (r_ch == LAST_CH);
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign bram_en   = w_issue;
    assign bram_addr = r_rd_addr;
    assign m_valid   = (r_cnt != 2'd0);
    assign m_data    = r_mem[r_rptr];
    assign m_chan    = r_ch;
    assign m_last    = m_valid && w_last_elem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_dvld    <= 1'b0;
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_cnt     <= 2'd0;
            r_pix     <= '0;
            r_ch      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dvld <= w_issue;
            r_cnt  <= r_cnt + {1'b0, r_dvld} - {1'b0, w_pop};

            if (r_dvld) begin
                r_mem[r_wptr] <= bram_dout;
                r_wptr        <= ~r_wptr;
            end

            if (w_pop) begin
                r_rptr <= ~r_rptr;
                if (w_plane_end) begin
                    r_pix <= '0;
                    r_ch  <= r_ch + CH_WIDTH'(1);
                end else begin
                    r_pix <= r_pix + PIX_W'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (r_rd_addr == LAST_ADDR) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_last_elem) begin
                        r_state   <= S_IDLE;
                        r_done    <= 1'b1;
                        r_rd_addr <= '0;
                        r_pix     <= '0;
                        r_ch      <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/fmap_stream_reader.md
FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, element width in bits.
- CHANNELS, default 128, feature-map channels.
- IN_HEIGHT, default 3, rows per channel.
- IN_WIDTH, default 4, columns per channel.
- ADDR_WIDTH, default 11, BRAM address width.
- CH_WIDTH, default 7, channel-index width.
REQ-002 TOTAL SHALL equal CHANNELS*IN_HEIGHT*IN_WIDTH (1536 at defaults); PLANE SHALL equal IN_HEIGHT*IN_WIDTH (12).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to stream one full feature map.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle completion pulse.
- bram_en  out  1  read enable to the feature-map BRAM port.
- bram_addr  out  ADDR_WIDTH  read address.
- bram_dout  in  DATA_WIDTH  signed read data, valid exactly 1 cycle after the bram_en cycle.
- m_valid  out  1  stream element valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  signed element.
- m_chan  out  CH_WIDTH  channel index of m_data.
- m_last  out  1  marks element TOTAL-1.

Function
REQ-005 The block SHALL read BRAM addresses 0..TOTAL-1 in ascending order, each exactly once per run. This matches the layout written by the upstream ReLU stage: address = ch*PLANE + row*IN_WIDTH + col.
REQ-006 States SHALL be IDLE, RUN and DRAIN:
- IDLE->RUN when start=1.
- RUN->DRAIN after the read of TOTAL-1 is issued.
- DRAIN->IDLE on the handshake of the m_last element.
REQ-007 start SHALL be ignored outside IDLE.
REQ-008 An internal 2-entry output FIFO SHALL hold BRAM data. A read SHALL be issued only when FIFO occupancy plus in-flight reads, minus a pop occurring in the same cycle, is less than 2, so that no datum is ever dropped.
REQ-009 With m_ready held at 1, throughput SHALL be 1 element per cycle after the first.
REQ-010 Latency: for start sampled at edge k, bram_en=1 with bram_addr=0 SHALL hold during cycle k..k+1, and m_valid SHALL rise after edge k+2 with m_data = contents of address 0.
REQ-011 A handshake SHALL occur when m_valid=1 and m_ready=1 at a rising edge.
REQ-012 While m_valid=1 and m_ready=0, m_data, m_chan and m_last SHALL hold stable, and m_valid SHALL not fall.
REQ-013 m_chan SHALL come from a pixel counter that wraps at PLANE-1 and a channel counter; no divider is used. m_chan SHALL increment at every PLANE-th element.
REQ-014 m_last SHALL be 1 only with element TOTAL-1.
REQ-015 done SHALL pulse for exactly one cycle after the edge at which the m_last handshake occurs; busy SHALL fall at that same edge.
REQ-016 bram_en SHALL be 0 whenever no read is issued. bram_addr SHALL never exceed TOTAL-1.
REQ-017 m_data SHALL pass through unmodified, with no saturation or ReLU re-applied.
REQ-018 After done, a new start SHALL restart from address 0 with all counters cleared.

Reset
REQ-019 While rst=1 at a rising edge, the following SHALL hold at that edge: state=IDLE; busy=0; done=0; bram_en=0; bram_addr=0; m_valid=0; m_data=0; m_chan=0; m_last=0; FIFO empty; in-flight count 0; all counters 0.
REQ-020 Reset asserted mid-run SHALL abort the run at that edge, and any in-flight BRAM data returned afterwards SHALL be discarded.
REQ-021 start asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-022 Continuous flow: BRAM preloaded with address mod 256; start pulse, m_ready=1 -> 1536 beats on consecutive cycles, data 0,1,...,255,0,...; m_chan steps 0..127 every 12 beats; m_last only on beat 1535; done 1 cycle after it.
REQ-023 Backpressure: m_ready toggled randomly, including 20-cycle stalls -> no lost or duplicated elements; outputs stable during stalls; bram_addr sequence strictly ascending.
REQ-024 Latency: start at edge k with m_ready=1 -> bram_addr=0 in cycle k+1; m_valid=1 after edge k+2; bram_addr=1 no later than cycle k+2.
REQ-025 Mid-run reset: rst asserted after beat 700 with m_ready=0 -> all outputs 0 next cycle; a subsequent start streams from address 0 and ends with m_last at element 1535.
REQ-026 Start while busy: start asserted at beat 100 -> ignored; total beat count remains exactly 1536; exactly one done pulse.
REQ-027 Signed data: address 5 holding -3 (0xFD) -> m_data = 0xFD on beat 5, with m_chan=0.
